// File: rtl/mem_bus_slice.sv
// Registered pipeline stage for the packed CPU memory bus with a per-transaction
// watchdog that answers a silent slave with an error-data acknowledge.
module mem_bus_slice #(
  parameter int          AW       = 32,
  parameter int          DW       = 32,
  parameter int          TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DW+DW/8+AW:0]  up_packed_fwd,
  output logic [DW:0]          up_packed_ret,
  output logic [DW+DW/8+AW:0]  dn_packed_fwd,
  input  logic [DW:0]          dn_packed_ret,
  output logic                 timeout_stb,
  output logic [15:0]          timeout_cnt
);

  localparam int SW = DW / 8;
  // The watchdog only has to count 0..TIMEOUT-1 before it fires.
  localparam int              WDW       = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [WDW-1:0]  WDOG_LAST = WDW'(TIMEOUT - 1);
  localparam bit              WDOG_EN   = (TIMEOUT != 0);
  localparam logic [DW-1:0]   ERR_DW    = DW'(ERR_DATA);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_ACK
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic          w_up_valid;
  logic [AW-1:0] w_up_addr;
  logic [SW-1:0] w_up_wstrb;
  logic [DW-1:0] w_up_wdata;
  logic          w_dn_ready;
  logic [DW-1:0] w_dn_rdata;

  logic          w_accept;
  logic          w_dn_done;
  logic          w_timeout;

  logic          r_dn_valid;
  logic [AW-1:0] r_dn_addr;
  logic [SW-1:0] r_dn_wstrb;
  logic [DW-1:0] r_dn_wdata;
  logic          r_up_ready;
  logic [DW-1:0] r_up_rdata;
  logic          r_timeout_stb;
  logic [15:0]   r_timeout_cnt;
  logic [WDW-1:0] r_wdog;

  assign w_up_valid = up_packed_fwd[0];
  assign w_up_addr  = up_packed_fwd[AW:1];
  assign w_up_wstrb = up_packed_fwd[AW+SW:AW+1];
  assign w_up_wdata = up_packed_fwd[AW+SW+DW:AW+SW+1];
  assign w_dn_ready = dn_packed_ret[DW];
  assign w_dn_rdata = dn_packed_ret[DW-1:0];

  always_ff @(posedge clk) begin
    // NOTE: sequential state always uses non-blocking assignment so every
    // register samples pre-edge values regardless of statement order.
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first; a path that
    // left one unassigned would infer a latch.
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_dn_done   = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_up_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = S_REQ;
        end
      end
      S_REQ: begin
        // A ready in the same cycle as expiry wins: real data beats error data.
        if (w_dn_ready) begin
          w_dn_done   = 1'b1;
          w_state_nxt = S_ACK;
        end else if (WDOG_EN && (r_wdog == WDOG_LAST)) begin
          w_timeout   = 1'b1;
          w_state_nxt = S_ACK;
        end
      end
      S_ACK:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_dn_valid    <= 1'b0;
      r_dn_addr     <= '0;
      r_dn_wstrb    <= '0;
      r_dn_wdata    <= '0;
      r_up_ready    <= 1'b0;
      r_up_rdata    <= '0;
      r_timeout_stb <= 1'b0;
      r_timeout_cnt <= '0;
      r_wdog        <= '0;
    end else begin
      r_up_ready    <= (w_state_nxt == S_ACK);
      r_timeout_stb <= w_timeout;

      if (w_accept) begin
        r_dn_valid <= 1'b1;
        r_dn_addr  <= w_up_addr;
        r_dn_wstrb <= w_up_wstrb;
        r_dn_wdata <= w_up_wdata;
        r_wdog     <= '0;
      end else begin
        if (w_dn_done || w_timeout) begin
          r_dn_valid <= 1'b0;
        end
        if (r_state == S_REQ) begin
          r_wdog <= r_wdog + 1'b1;
        end
      end

      // rdata holds between acknowledges; masters qualify it with ready.
      if (w_dn_done) begin
        r_up_rdata <= w_dn_rdata;
      end else if (w_timeout) begin
        r_up_rdata <= ERR_DW;
      end

      if (w_timeout && (r_timeout_cnt != 16'hFFFF)) begin
        r_timeout_cnt <= r_timeout_cnt + 16'd1;
      end
    end
  end

  assign dn_packed_fwd = {r_dn_wdata, r_dn_wstrb, r_dn_addr, r_dn_valid};
  assign up_packed_ret = {r_up_ready, r_up_rdata};
  assign timeout_stb   = r_timeout_stb;
  assign timeout_cnt   = r_timeout_cnt;

endmodule

// File: tb/tb_mem_bus_slice.sv
// Directed bench for mem_bus_slice: a 32/32 instance and a 24/64 instance,
// both with an 8-cycle watchdog, exercised one scenario per task.
module tb_mem_bus_slice;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------- instance A: AW=32, DW=32 ----------------
  logic        rst_a;
  logic        a_valid;
  logic [31:0] a_addr;
  logic [3:0]  a_wstrb;
  logic [31:0] a_wdata;
  logic        a_s_ready;
  logic [31:0] a_s_rdata;
  logic [68:0] a_up_fwd, a_dn_fwd;
  logic [32:0] a_up_ret, a_dn_ret;
  logic        a_stb;
  logic [15:0] a_cnt;

  assign a_up_fwd = {a_wdata, a_wstrb, a_addr, a_valid};
  assign a_dn_ret = {a_s_ready, a_s_rdata};

  logic        a_dn_valid, a_up_ready;
  logic [31:0] a_dn_addr, a_dn_wdata, a_up_rdata;
  logic [3:0]  a_dn_wstrb;
  assign a_dn_valid = a_dn_fwd[0];
  assign a_dn_addr  = a_dn_fwd[32:1];
  assign a_dn_wstrb = a_dn_fwd[36:33];
  assign a_dn_wdata = a_dn_fwd[68:37];
  assign a_up_ready = a_up_ret[32];
  assign a_up_rdata = a_up_ret[31:0];

  mem_bus_slice #(.AW(32), .DW(32), .TIMEOUT(8)) dut_a (
    .clk           (clk),
    .rst           (rst_a),
    .up_packed_fwd (a_up_fwd),
    .up_packed_ret (a_up_ret),
    .dn_packed_fwd (a_dn_fwd),
    .dn_packed_ret (a_dn_ret),
    .timeout_stb   (a_stb),
    .timeout_cnt   (a_cnt)
  );

  // ---------------- instance B: AW=24, DW=64 ----------------
  logic        rst_b;
  logic        b_valid;
  logic [23:0] b_addr;
  logic [7:0]  b_wstrb;
  logic [63:0] b_wdata;
  logic        b_s_ready;
  logic [63:0] b_s_rdata;
  logic [96:0] b_up_fwd, b_dn_fwd;
  logic [64:0] b_up_ret, b_dn_ret;
  logic        b_stb;
  logic [15:0] b_cnt;

  assign b_up_fwd = {b_wdata, b_wstrb, b_addr, b_valid};
  assign b_dn_ret = {b_s_ready, b_s_rdata};

  logic        b_dn_valid, b_up_ready;
  logic [23:0] b_dn_addr;
  logic [7:0]  b_dn_wstrb;
  logic [63:0] b_dn_wdata, b_up_rdata;
  assign b_dn_valid = b_dn_fwd[0];
  assign b_dn_addr  = b_dn_fwd[24:1];
  assign b_dn_wstrb = b_dn_fwd[32:25];
  assign b_dn_wdata = b_dn_fwd[96:33];
  assign b_up_ready = b_up_ret[64];
  assign b_up_rdata = b_up_ret[63:0];

  mem_bus_slice #(.AW(24), .DW(64), .TIMEOUT(8)) dut_b (
    .clk           (clk),
    .rst           (rst_b),
    .up_packed_fwd (b_up_fwd),
    .up_packed_ret (b_up_ret),
    .dn_packed_fwd (b_dn_fwd),
    .dn_packed_ret (b_dn_ret),
    .timeout_stb   (b_stb),
    .timeout_cnt   (b_cnt)
  );

  // Advance one cycle; outputs are then stable for sampling and inputs may change.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_a = 1'b1;
    rst_b = 1'b1;
    repeat (3) tick();
    rst_a = 1'b0;
    rst_b = 1'b0;
    checks++; if (a_dn_fwd !== 69'd0) begin errors++; $display("FAIL rst_a_dn_fwd: got %0h expected 0", a_dn_fwd); end
    checks++; if (a_up_ret !== 33'd0) begin errors++; $display("FAIL rst_a_up_ret: got %0h expected 0", a_up_ret); end
    checks++; if ({a_stb, a_cnt} !== 17'd0) begin errors++; $display("FAIL rst_a_timeout: got %0h expected 0", {a_stb, a_cnt}); end
    checks++; if (b_dn_fwd !== 97'd0) begin errors++; $display("FAIL rst_b_dn_fwd: got %0h expected 0", b_dn_fwd); end
    checks++; if (b_up_ret !== 65'd0) begin errors++; $display("FAIL rst_b_up_ret: got %0h expected 0", b_up_ret); end
    checks++; if ({b_stb, b_cnt} !== 17'd0) begin errors++; $display("FAIL rst_b_timeout: got %0h expected 0", {b_stb, b_cnt}); end
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if ({a_dn_valid, a_up_ready, b_dn_valid, b_up_ready} !== 4'b0000) begin
        errors++;
        $display("FAIL idle_cycle%0d: got %b expected 0000", i, {a_dn_valid, a_up_ready, b_dn_valid, b_up_ready});
      end
    end
  endtask

  task automatic test_zero_wait_read();
    a_valid = 1'b1; a_addr = 32'h0000_1000; a_wstrb = 4'h0; a_wdata = 32'h0;
    tick();  // cycle 1
    checks++; if ({a_dn_valid, a_dn_addr} !== {1'b1, 32'h0000_1000}) begin errors++; $display("FAIL zw_dn_c1: got %0h expected %0h", {a_dn_valid, a_dn_addr}, {1'b1, 32'h0000_1000}); end
    checks++; if (a_up_ready !== 1'b0) begin errors++; $display("FAIL zw_ready_c1: got %b expected 0", a_up_ready); end
    a_valid = 1'b0; a_s_ready = 1'b1; a_s_rdata = 32'h1234_5678;
    tick();  // cycle 2
    checks++; if ({a_up_ready, a_up_rdata} !== {1'b1, 32'h1234_5678}) begin errors++; $display("FAIL zw_ack_c2: got %0h expected %0h", {a_up_ready, a_up_rdata}, {1'b1, 32'h1234_5678}); end
    checks++; if (a_dn_valid !== 1'b0) begin errors++; $display("FAIL zw_dn_drop_c2: got %b expected 0", a_dn_valid); end
    a_s_ready = 1'b0;
    tick();  // cycle 3
    checks++; if (a_up_ready !== 1'b0) begin errors++; $display("FAIL zw_ready_c3: got %b expected 0", a_up_ready); end
  endtask

  task automatic test_wait_state_write();
    int ready_seen;
    ready_seen = 0;
    a_valid = 1'b1; a_addr = 32'h0000_2000; a_wstrb = 4'b0011; a_wdata = 32'hCAFE_F00D;
    tick();
    a_valid = 1'b0; a_addr = 32'h0; a_wstrb = 4'h0; a_wdata = 32'h0;  // fields must not follow the bus
    for (int c = 1; c <= 5; c++) begin
      checks++;
      if ({a_dn_valid, a_dn_wdata, a_dn_wstrb, a_dn_addr} !== {1'b1, 32'hCAFE_F00D, 4'b0011, 32'h0000_2000}) begin
        errors++;
        $display("FAIL ws_dn_fields_c%0d: got %0h expected %0h", c, {a_dn_valid, a_dn_wdata, a_dn_wstrb, a_dn_addr}, {1'b1, 32'hCAFE_F00D, 4'b0011, 32'h0000_2000});
      end
      if (a_up_ready) ready_seen++;
      if (c == 5) begin a_s_ready = 1'b1; a_s_rdata = 32'h0000_0000; end
      tick();
    end
    checks++; if ({a_up_ready, a_dn_valid} !== 2'b10) begin errors++; $display("FAIL ws_ack_c6: got %b expected 10", {a_up_ready, a_dn_valid}); end
    if (a_up_ready) ready_seen++;
    a_s_ready = 1'b0;
    tick();
    if (a_up_ready) ready_seen++;
    checks++; if (ready_seen !== 1) begin errors++; $display("FAIL ws_ready_count: got %0d expected 1", ready_seen); end
  endtask

  task automatic test_timeout();
    a_valid = 1'b1; a_addr = 32'h0000_3000; a_wstrb = 4'h0;
    tick();
    a_valid = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      checks++;
      if ({a_dn_valid, a_up_ready, a_stb} !== 3'b100) begin
        errors++;
        $display("FAIL to_req_c%0d: got %b expected 100", c, {a_dn_valid, a_up_ready, a_stb});
      end
      tick();
    end
    checks++; if ({a_dn_valid, a_up_ready, a_stb} !== 3'b011) begin errors++; $display("FAIL to_ack_flags: got %b expected 011", {a_dn_valid, a_up_ready, a_stb}); end
    checks++; if (a_up_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL to_ack_rdata: got %0h expected deadbeef", a_up_rdata); end
    checks++; if (a_cnt !== 16'd1) begin errors++; $display("FAIL to_cnt: got %0d expected 1", a_cnt); end
    a_s_ready = 1'b1; a_s_rdata = 32'h1111_1111;  // late answer from the slave
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++;
      if ({a_dn_valid, a_up_ready, a_stb, a_cnt, a_up_rdata} !== {3'b000, 16'd1, 32'hDEAD_BEEF}) begin
        errors++;
        $display("FAIL to_late_ready_%0d: got %0h expected %0h", c, {a_dn_valid, a_up_ready, a_stb, a_cnt, a_up_rdata}, {3'b000, 16'd1, 32'hDEAD_BEEF});
      end
    end
    a_s_ready = 1'b0;
  endtask

  task automatic test_race();
    a_valid = 1'b1; a_addr = 32'h0000_3004; a_wstrb = 4'h0;
    tick();
    a_valid = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      checks++;
      if ({a_dn_valid, a_up_ready} !== 2'b10) begin errors++; $display("FAIL race_req_c%0d: got %b expected 10", c, {a_dn_valid, a_up_ready}); end
      if (c == 8) begin a_s_ready = 1'b1; a_s_rdata = 32'h5A5A_5A5A; end
      tick();
    end
    a_s_ready = 1'b0;
    checks++; if ({a_up_ready, a_up_rdata} !== {1'b1, 32'h5A5A_5A5A}) begin errors++; $display("FAIL race_ack: got %0h expected %0h", {a_up_ready, a_up_rdata}, {1'b1, 32'h5A5A_5A5A}); end
    checks++; if ({a_stb, a_cnt} !== {1'b0, 16'd1}) begin errors++; $display("FAIL race_timeout: got %0h expected %0h", {a_stb, a_cnt}, {1'b0, 16'd1}); end
    tick();
  endtask

  task automatic test_back_to_back();
    a_valid = 1'b1; a_addr = 32'h0000_4000; a_wstrb = 4'h0;
    tick();  // cycle 1: REQ
    a_s_ready = 1'b1; a_s_rdata = 32'h0000_0001; a_addr = 32'h0000_5000;
    tick();  // cycle 2: ACK, valid still high and must be ignored
    checks++; if ({a_up_ready, a_up_rdata} !== {1'b1, 32'h0000_0001}) begin errors++; $display("FAIL b2b_ack1: got %0h expected %0h", {a_up_ready, a_up_rdata}, {1'b1, 32'h0000_0001}); end
    a_s_ready = 1'b0;
    tick();  // cycle 3: IDLE, request sampled at the end of this cycle
    checks++; if ({a_dn_valid, a_up_ready} !== 2'b00) begin errors++; $display("FAIL b2b_idle_gap: got %b expected 00", {a_dn_valid, a_up_ready}); end
    tick();  // cycle 4: second REQ
    checks++; if ({a_dn_valid, a_dn_addr} !== {1'b1, 32'h0000_5000}) begin errors++; $display("FAIL b2b_req2: got %0h expected %0h", {a_dn_valid, a_dn_addr}, {1'b1, 32'h0000_5000}); end
    a_valid = 1'b0; a_s_ready = 1'b1; a_s_rdata = 32'h0000_0002;
    tick();  // cycle 5: second ACK
    checks++; if ({a_up_ready, a_up_rdata} !== {1'b1, 32'h0000_0002}) begin errors++; $display("FAIL b2b_ack2: got %0h expected %0h", {a_up_ready, a_up_rdata}, {1'b1, 32'h0000_0002}); end
    a_s_ready = 1'b0;
    tick();
  endtask

  task automatic test_wide_timeout();
    b_valid = 1'b1; b_addr = 24'h00_0100; b_wstrb = 8'h00;
    tick();
    b_valid = 1'b0;
    repeat (8) tick();
    checks++; if ({b_up_ready, b_stb, b_up_rdata} !== {2'b11, 64'h0000_0000_DEAD_BEEF}) begin errors++; $display("FAIL wide_to_ack: got %0h expected %0h", {b_up_ready, b_stb, b_up_rdata}, {2'b11, 64'h0000_0000_DEAD_BEEF}); end
    checks++; if (b_cnt !== 16'd1) begin errors++; $display("FAIL wide_to_cnt: got %0d expected 1", b_cnt); end
    tick();
  endtask

  task automatic test_mid_reset();
    b_valid = 1'b1; b_addr = 24'hAB_CDEF; b_wstrb = 8'h00;
    tick();  // REQ cycle 1
    b_valid = 1'b0;
    tick();  // REQ cycle 2
    tick();  // REQ cycle 3
    checks++; if (b_dn_valid !== 1'b1) begin errors++; $display("FAIL mr_req3: got %b expected 1", b_dn_valid); end
    rst_b = 1'b1;
    tick();
    rst_b = 1'b0;
    checks++; if ({b_dn_valid, b_up_ready, b_cnt} !== {2'b00, 16'd0}) begin errors++; $display("FAIL mr_after_rst: got %0h expected 0", {b_dn_valid, b_up_ready, b_cnt}); end
    b_s_ready = 1'b1; b_s_rdata = 64'h7777_7777_7777_7777;
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++;
      if ({b_dn_valid, b_up_ready} !== 2'b00) begin errors++; $display("FAIL mr_late_ready_%0d: got %b expected 00", c, {b_dn_valid, b_up_ready}); end
    end
    b_s_ready = 1'b0;
  endtask

  task automatic test_wide_write();
    b_valid = 1'b1; b_addr = 24'h12_3456; b_wstrb = 8'hF0; b_wdata = 64'h0123_4567_89AB_CDEF;
    tick();
    b_valid = 1'b0;
    checks++;
    if ({b_dn_valid, b_dn_wdata, b_dn_wstrb, b_dn_addr} !== {1'b1, 64'h0123_4567_89AB_CDEF, 8'hF0, 24'h12_3456}) begin
      errors++;
      $display("FAIL ww_dn_fields: got %0h expected %0h", {b_dn_valid, b_dn_wdata, b_dn_wstrb, b_dn_addr}, {1'b1, 64'h0123_4567_89AB_CDEF, 8'hF0, 24'h12_3456});
    end
    b_s_ready = 1'b1; b_s_rdata = 64'hFEDC_BA98_7654_3210;
    tick();
    b_s_ready = 1'b0;
    checks++; if ({b_up_ready, b_up_rdata} !== {1'b1, 64'hFEDC_BA98_7654_3210}) begin errors++; $display("FAIL ww_ack: got %0h expected %0h", {b_up_ready, b_up_rdata}, {1'b1, 64'hFEDC_BA98_7654_3210}); end
    tick();
    checks++; if (b_up_ready !== 1'b0) begin errors++; $display("FAIL ww_ready_drop: got %b expected 0", b_up_ready); end
  endtask

  initial begin
    rst_a = 1'b1; rst_b = 1'b1;
    a_valid = 1'b0; a_addr = '0; a_wstrb = '0; a_wdata = '0; a_s_ready = 1'b0; a_s_rdata = '0;
    b_valid = 1'b0; b_addr = '0; b_wstrb = '0; b_wdata = '0; b_s_ready = 1'b0; b_s_rdata = '0;
    test_reset();
    test_zero_wait_read();
    test_wait_state_write();
    test_timeout();
    test_race();
    test_back_to_back();
    test_wide_timeout();
    test_mid_reset();
    test_wide_write();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
